rect_fill_engine: RTL
=====================

Name: rect_fill_engine

Overview:
- Drawing stage upstream of the framebuffer that vga_xy_controller scans out (160x120, 3-bit colour).
- Accepts one filled-rectangle command through a valid/ready handshake.
- Emits one framebuffer write per accepted cycle, in raster order, with backpressure from the framebuffer write port.
- Replaces the static background ROM image with run-time drawn content.

Parameters:
- X_W, 8, width of x coordinates
- Y_W, 7, width of y coordinates
- COLOR_W, 3, pixel colour width (R,G,B bits)
- X_MAX, 159, last visible column
- Y_MAX, 119, last visible row

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0  in  X_W  corner A column
- cmd_y0  in  Y_W  corner A row
- cmd_x1  in  X_W  corner B column
- cmd_y1  in  Y_W  corner B row
- cmd_color  in  COLOR_W  fill colour
- wr_en  out  1  framebuffer write request
- wr_ready  in  1  framebuffer accepts the write this cycle
- wr_x  out  X_W  write column
- wr_y  out  Y_W  write row
- wr_color  out  COLOR_W  write colour
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset (resetn low at a rising edge): state=IDLE; cmd_ready=1 from the following cycle; wr_en=0, wr_x=0, wr_y=0, wr_color=0, busy=0, done=0. Reset mid-fill drops the command; no further writes occur.
- States: IDLE, CLIP, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register x0,y0,x1,y1,color and go to CLIP.
  - cmd_ready=0 in all other states.
- CLIP (exactly 1 cycle):
  - x_lo=min(x0,x1), x_hi=max(x0,x1); same for y.
  - x_hi clamped to X_MAX; y_hi clamped to Y_MAX.
  - If x_lo>X_MAX or y_lo>Y_MAX, the rectangle is empty: go to DONE with zero writes.
  - Otherwise load cur_x=x_lo, cur_y=y_lo and go to FILL.
- FILL:
  - wr_en=1; wr_x=cur_x, wr_y=cur_y, wr_color=registered colour.
  - Outputs stay stable while wr_ready=0.
  - On wr_en&wr_ready:
    - If cur_x<x_hi: cur_x++.
    - Else if cur_y<y_hi: cur_x=x_lo, cur_y++.
    - Else go to DONE; wr_en=0 next cycle.
  - Compare against x_hi before incrementing, so there is no counter wrap at X_W/Y_W limits.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in CLIP, FILL and DONE.
- Latency:
  - Command accepted at edge N; first wr_en at cycle N+2.
  - With wr_ready tied high, a WxH rectangle issues W*H writes on consecutive cycles.
  - done is asserted in the cycle after the last write handshake.
  - The next command can be accepted 1 cycle after done.
- A single pixel (x0=x1, y0=y1) gives exactly one write.
- cmd_valid is ignored while busy; the command source must hold it until cmd_ready.
- No writes are ever issued outside 0..X_MAX / 0..Y_MAX.

Test Plan:
- Reset, then cmd (x0=10,y0=5,x1=12,y1=6,color=3'b100) with wr_ready=1 -> 6 writes in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), all colour 4; first wr_en 2 cycles after accept; done pulse 1 cycle after last write; cmd_ready high the cycle after done.
- Swapped corners (x0=20,y0=9,x1=18,y1=8) -> same raster as (18,8)-(20,9): 6 writes starting at (18,8).
- Clipping: (x0=157,y0=118,x1=200,y1=127) -> writes only x 157..159, y 118..119 (6 writes). Fully off-screen (x0=170,x1=180) -> zero writes, done 2 cycles after accept.
- Backpressure: 2x1 rect with wr_ready toggling 0,0,1,0,1 -> wr_x/wr_y/wr_color constant during stalls; exactly 2 handshakes; done after the second.
- Full screen (0,0)-(159,119), wr_ready=1 -> 19200 writes; last write (159,119); no write beyond it; no counter wrap.
- resetn low during the 3rd write of a 4x4 fill -> wr_en=0, busy=0 next cycle; after release, a new 1x1 command (5,5) produces exactly one write (5,5).

Source files
------------

// File: rtl/rect_fill_if.sv
// Command and framebuffer-write bundle for rect_fill_engine.
// The engine connects through the slave modport; the command source and framebuffer side use master.
interface rect_fill_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [X_W-1:0]     cmd_x0;
  logic [Y_W-1:0]     cmd_y0;
  logic [X_W-1:0]     cmd_x1;
  logic [Y_W-1:0]     cmd_y1;
  logic [COLOR_W-1:0] cmd_color;
  logic               wr_en;
  logic               wr_ready;
  logic [X_W-1:0]     wr_x;
  logic [Y_W-1:0]     wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, wr_ready,
    input  cmd_ready, wr_en, wr_x, wr_y, wr_color, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, wr_ready,
    output cmd_ready, wr_en, wr_x, wr_y, wr_color, busy, done
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Filled-rectangle drawing engine: accepts one command, clips it to the visible area,
// and streams framebuffer writes in raster order under wr_ready backpressure.
module rect_fill_engine #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  rect_fill_if.slave   bus
);
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  state_t             state_q, state_d;
  logic [X_W-1:0]     x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]     y0_q, y0_d, y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [X_W-1:0]     x_lo_q, x_lo_d, x_hi_q, x_hi_d;
  logic [Y_W-1:0]     y_hi_q, y_hi_d;
  logic [X_W-1:0]     wr_x_q, wr_x_d;
  logic [Y_W-1:0]     wr_y_q, wr_y_d;
  logic [COLOR_W-1:0] wr_color_q, wr_color_d;
  logic               wr_en_q, wr_en_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [X_W-1:0]     x_lo_c, x_hi_c;
  logic [Y_W-1:0]     y_lo_c, y_hi_c;

  always_comb begin
    x_lo_c = (x0_q < x1_q) ? x0_q : x1_q;
    x_hi_c = (x0_q < x1_q) ? x1_q : x0_q;
    y_lo_c = (y0_q < y1_q) ? y0_q : y1_q;
    y_hi_c = (y0_q < y1_q) ? y1_q : y0_q;
    if (x_hi_c > X_LIM) x_hi_c = X_LIM;
    if (y_hi_c > Y_LIM) y_hi_c = Y_LIM;
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    color_d     = color_q;
    x_lo_d      = x_lo_q;
    x_hi_d      = x_hi_q;
    y_hi_d      = y_hi_q;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_color_d  = wr_color_q;
    wr_en_d     = wr_en_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = done_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          x0_d        = bus.cmd_x0;
          y0_d        = bus.cmd_y0;
          x1_d        = bus.cmd_x1;
          y1_d        = bus.cmd_y1;
          color_d     = bus.cmd_color;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = CLIP;
        end
      end
      CLIP: begin
        x_lo_d = x_lo_c;
        x_hi_d = x_hi_c;
        y_hi_d = y_hi_c;
        if (x_lo_c > X_LIM || y_lo_c > Y_LIM) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          wr_x_d     = x_lo_c;
          wr_y_d     = y_lo_c;
          wr_color_d = color_q;
          wr_en_d    = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        // Test against the bound before stepping so the counters never pass x_hi/y_hi.
        if (bus.wr_ready) begin
          if (wr_x_q < x_hi_q) begin
            wr_x_d = wr_x_q + X_W'(1);
          end else if (wr_y_q < y_hi_q) begin
            wr_x_d = x_lo_q;
            wr_y_d = wr_y_q + Y_W'(1);
          end else begin
            wr_en_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d      = 1'b0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      x_lo_q      <= '0;
      x_hi_q      <= '0;
      y_hi_q      <= '0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_color_q  <= '0;
      wr_en_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      x_lo_q      <= x_lo_d;
      x_hi_q      <= x_hi_d;
      y_hi_q      <= y_hi_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_color_q  <= wr_color_d;
      wr_en_q     <= wr_en_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_x      = wr_x_q;
  assign bus.wr_y      = wr_y_q;
  assign bus.wr_color  = wr_color_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
